ov7670_cam_emu: RTL and testbench

Synthesizable emulator of the OV7670 camera's parallel video output (PCLK, VSYNC, HREF, D[7:0]), producing RGB565 test patterns at configurable QVGA-class geometry. It drives the same pins that the capture path samples, so capture, frame buffer and VGA display can be brought up and regression-tested on the board or in simulation without a sensor attached. It sits in the 50 MHz domain and replaces the camera-side inputs through a top-level mux.

---
 rtl/ov7670_emu_pkg.sv | 34 +++
 rtl/ov7670_emu_pattern.sv | 96 +++++++++
 rtl/ov7670_cam_emu.sv | 197 +++++++++++++++++++
 tb/tb_ov7670_cam_emu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_emu_pkg.sv
// Shared states, pattern codes and RGB565 constants for the OV7670 camera emulator.
package ov7670_emu_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_VSYNC, ST_VBP, ST_ACTIVE, ST_VFP} emu_state_e;
  typedef enum logic [1:0] {PAT_BARS, PAT_GRADIENT, PAT_CHECKER, PAT_RAMP} pattern_e;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  localparam logic [7:0] STAMP_MARKER = 8'hA5;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] color;
    color = BAR_BLACK;
    case (idx)
      3'd0: color = BAR_WHITE;
      3'd1: color = BAR_YELLOW;
      3'd2: color = BAR_CYAN;
      3'd3: color = BAR_GREEN;
      3'd4: color = BAR_MAGENTA;
      3'd5: color = BAR_RED;
      3'd6: color = BAR_BLUE;
      default: color = BAR_BLACK;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/ov7670_emu_pattern.sv
// Registered RGB565 test-pattern generator, stepped by per-pixel and per-row strobes.
module ov7670_emu_pattern
  import ov7670_emu_pkg::*;
#(
  parameter int c_img_cols = 320,
  parameter int c_img_rows = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        col_adv,
  input  logic        row_adv,
  input  logic [1:0]  pattern_sel,
  output logic [15:0] pixel
);

  localparam int COL_W   = (c_img_cols > 1) ? $clog2(c_img_cols) : 1;
  localparam int ROW_W   = (c_img_rows > 1) ? $clog2(c_img_rows) : 1;
  localparam int BAR_PIX = c_img_cols / 8;
  localparam int BAR_W   = (BAR_PIX > 1) ? $clog2(BAR_PIX) : 1;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [15:0]      ramp_q, ramp_d;
  logic [BAR_W-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  pattern_e         pat_q, pat_d;
  logic [15:0]      pixel_q, pixel_d;
  logic [4:0]       col5;
  logic [5:0]       row6;

  // Pixel is computed from the next counter values so it is ready one PCLK ahead of its bytes.
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    ramp_d    = ramp_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    pat_d     = pat_q;
    if (frame_start) begin
      col_d     = '0;
      row_d     = '0;
      ramp_d    = '0;
      bar_cnt_d = '0;
      bar_idx_d = '0;
      pat_d     = pattern_e'(pattern_sel);
    end else if (row_adv) begin
      col_d     = '0;
      row_d     = row_q + 1'b1;
      ramp_d    = ramp_q + 16'd1;
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else if (col_adv) begin
      col_d  = col_q + 1'b1;
      ramp_d = ramp_q + 16'd1;
      if (bar_cnt_q == BAR_W'(BAR_PIX - 1)) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + 1'b1;
      end
    end

    col5 = 5'(col_d);
    row6 = 6'(row_d);
    case (pat_d)
      PAT_BARS:     pixel_d = bar_color(bar_idx_d);
      PAT_GRADIENT: pixel_d = {col5, row6, col5 ^ row6[4:0]};
      PAT_CHECKER:  pixel_d = (col5[3] ^ row6[3]) ? 16'hFFFF : 16'h0000;
      default:      pixel_d = ramp_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      ramp_q    <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      pat_q     <= PAT_BARS;
      pixel_q   <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      ramp_q    <= ramp_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
      pixel_q   <= pixel_d;
    end
  end

  assign pixel = pixel_q;

endmodule

// File: rtl/ov7670_cam_emu.sv
// OV7670 parallel video emulator: PCLK divider, frame FSM, line counters and byte mux.
// Define OV7670_EMU_FRAME_STAMP_EN to replace pixel (0,0) with {8'hA5, frame count}.
module ov7670_cam_emu
  import ov7670_emu_pkg::*;
#(
  parameter int c_img_cols    = 320,
  parameter int c_img_rows    = 240,
  parameter int c_pclk_div    = 2,
  parameter int c_hblank      = 144,
  parameter int c_vsync_lines = 3,
  parameter int c_vbp_lines   = 17,
  parameter int c_vfp_lines   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       pclk,
  output logic       vsync,
  output logic       href,
  output logic [7:0] data,
  output logic       frame_done,
  output logic       busy
);

  localparam int LINE_LEN  = 2 * c_img_cols + c_hblank;
  localparam int ACT_BYTES = 2 * c_img_cols;
  localparam int COL_W     = $clog2(LINE_LEN + 1);
  localparam int MAX_AB    = (c_vsync_lines > c_vbp_lines) ? c_vsync_lines : c_vbp_lines;
  localparam int MAX_CD    = (c_img_rows > c_vfp_lines) ? c_img_rows : c_vfp_lines;
  localparam int MAX_LINES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int LINE_W    = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
  localparam int DIV_W     = (c_pclk_div > 1) ? $clog2(c_pclk_div) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(c_pclk_div - 1);
  localparam emu_state_e FIRST_STATE = emu_state_e'((c_vsync_lines > 0) ? ST_VSYNC :
                                                    (c_vbp_lines > 0)   ? ST_VBP : ST_ACTIVE);

  emu_state_e        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              pclk_q, pclk_d;
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic [7:0]        data_q, data_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              fall, frame_end, frame_start, col_adv, row_adv;
  logic [15:0]       pixel;
`ifdef OV7670_EMU_FRAME_STAMP_EN
  logic [7:0]        frame_cnt_q, frame_cnt_d;
`endif

  function automatic logic [LINE_W-1:0] last_line(input emu_state_e s);
    logic [LINE_W-1:0] n;
    case (s)
      ST_VSYNC:  n = LINE_W'(c_vsync_lines - 1);
      ST_VBP:    n = LINE_W'(c_vbp_lines - 1);
      ST_ACTIVE: n = LINE_W'(c_img_rows - 1);
      default:   n = LINE_W'(c_vfp_lines - 1);
    endcase
    return n;
  endfunction

  ov7670_emu_pattern #(
    .c_img_cols(c_img_cols),
    .c_img_rows(c_img_rows)
  ) u_pattern (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .col_adv    (col_adv),
    .row_adv    (row_adv),
    .pattern_sel(pattern_sel),
    .pixel      (pixel)
  );

  // PCLK only runs while a frame is pending, so an idle emulator leaves the bus quiet.
  always_comb begin
    div_d       = div_q;
    pclk_d      = pclk_q;
    state_d     = state_q;
    col_d       = col_q;
    line_d      = line_q;
    frame_end   = 1'b0;
    frame_start = 1'b0;
    fall        = pclk_q && (div_q == DIV_LAST);

    if ((state_q != ST_IDLE) || enable || pclk_q) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        pclk_d = ~pclk_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    if (fall) begin
      if (state_q == ST_IDLE) begin
        if (enable) begin
          state_d     = FIRST_STATE;
          frame_start = 1'b1;
          col_d       = '0;
          line_d      = '0;
        end
      end else if (col_q == COL_W'(LINE_LEN - 1)) begin
        col_d = '0;
        if (line_q == last_line(state_q)) begin
          line_d = '0;
          case (state_q)
            ST_VSYNC:  state_d = (c_vbp_lines > 0) ? ST_VBP : ST_ACTIVE;
            ST_VBP:    state_d = ST_ACTIVE;
            ST_ACTIVE: if (c_vfp_lines > 0) state_d = ST_VFP; else frame_end = 1'b1;
            default:   frame_end = 1'b1;
          endcase
          if (frame_end) begin
            frame_start = enable;
            state_d     = enable ? FIRST_STATE : ST_IDLE;
          end
        end else begin
          line_d = line_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Bus outputs describe the PCLK period that begins at this falling edge.
  always_comb begin
    vsync_d = vsync_q;
    href_d  = href_q;
    data_d  = data_q;
    if (fall) begin
      vsync_d = (state_d == ST_VSYNC);
      href_d  = (state_d == ST_ACTIVE) && (col_d < COL_W'(ACT_BYTES));
      data_d  = 8'h00;
      if (href_d) begin
        data_d = col_d[0] ? pixel[7:0] : pixel[15:8];
`ifdef OV7670_EMU_FRAME_STAMP_EN
        if ((line_d == '0) && (col_d < COL_W'(2))) begin
          data_d = col_d[0] ? frame_cnt_q : STAMP_MARKER;
        end
`endif
      end
    end
    col_adv      = fall && href_d && col_d[0] && (col_d != COL_W'(ACT_BYTES - 1));
    row_adv      = fall && href_d && (col_d == COL_W'(ACT_BYTES - 1));
    frame_done_d = frame_end;
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      col_q        <= '0;
      line_q       <= '0;
      pclk_q       <= 1'b0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      data_q       <= 8'h00;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      col_q        <= col_d;
      line_q       <= line_d;
      pclk_q       <= pclk_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

`ifdef OV7670_EMU_FRAME_STAMP_EN
  always_comb begin
    frame_cnt_d = frame_end ? frame_cnt_q + 8'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= 8'h00;
    else     frame_cnt_q <= frame_cnt_d;
  end
`endif

  assign pclk       = pclk_q;
  assign vsync      = vsync_q;
  assign href       = href_q;
  assign data       = data_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ov7670_cam_emu.sv
// Randomized bench for ov7670_cam_emu against a frame-level reference model.
// With OV7670_EMU_FRAME_STAMP_EN defined the model also expects the per-frame stamp.
`timescale 1ns/1ps
module tb_ov7670_cam_emu;

  localparam int COLS  = 8;
  localparam int ROWS  = 4;
  localparam int HBL   = 4;
  localparam int VS    = 1;
  localparam int VBP   = 1;
  localparam int VFP   = 1;
  localparam int DIV   = 1;
  localparam int L     = 2 * COLS + HBL;
  localparam int FRAME = (VS + VBP + ROWS + VFP) * L;
`ifdef OV7670_EMU_FRAME_STAMP_EN
  localparam bit STAMP_EN = 1'b1;
`else
  localparam bit STAMP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] pattern_sel;
  logic       pclk, vsync, href, frame_done, busy;
  logic [7:0] data;

  int   total = 0;
  int   bad = 0;
  int   fd_cnt = 0;
  logic prev_pclk = 1'b0;

  ov7670_cam_emu #(
    .c_img_cols(COLS), .c_img_rows(ROWS), .c_pclk_div(DIV), .c_hblank(HBL),
    .c_vsync_lines(VS), .c_vbp_lines(VBP), .c_vfp_lines(VFP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .pclk(pclk), .vsync(vsync), .href(href), .data(data),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pixel value straight from the pattern definitions.
  function automatic logic [15:0] refPixel(input int pat, input int row, input int col);
    logic [15:0] pix;
    int r, g, b;
    case (pat)
      0: begin
        case (col / (COLS / 8))
          0: pix = 16'hFFFF;
          1: pix = 16'hFFE0;
          2: pix = 16'h07FF;
          3: pix = 16'h07E0;
          4: pix = 16'hF81F;
          5: pix = 16'hF800;
          6: pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      1: begin
        r = col % 32;
        g = row % 64;
        b = (col % 32) ^ (row % 32);
        pix = 16'(r * 2048 + g * 32 + b);
      end
      2: pix = (((col / 8) % 2) != ((row / 8) % 2)) ? 16'hFFFF : 16'h0000;
      default: pix = 16'((row * COLS + col) % 65536);
    endcase
    return pix;
  endfunction

  // Expected {vsync, href, data} at PCLK number idx of frame number fno.
  function automatic logic [9:0] refSample(input int pat, input int fno, input int idx);
    int line, pos, row, col;
    logic vs, hr;
    logic [7:0] b;
    logic [15:0] pix;
    line = idx / L;
    pos  = idx % L;
    vs   = (line < VS);
    hr   = (line >= VS + VBP) && (line < VS + VBP + ROWS) && (pos < 2 * COLS);
    b    = 8'h00;
    if (hr) begin
      row = line - VS - VBP;
      col = pos / 2;
      pix = refPixel(pat, row, col);
      if (STAMP_EN && row == 0 && col == 0) pix = 16'hA500 | 16'(fno % 256);
      b = (pos % 2 == 0) ? pix[15:8] : pix[7:0];
    end
    return {vs, hr, b};
  endfunction

  task automatic tick();
    @(negedge clk);
    if (frame_done === 1'b1) fd_cnt++;
    prev_pclk = pclk;
  endtask

  task automatic nextRise(output logic [9:0] s);
    logic was;
    s = '0;
    for (int n = 0; n < 4 * DIV + 4; n++) begin
      was = prev_pclk;
      tick();
      if (!was && pclk === 1'b1) begin
        s = {vsync, href, data};
        return;
      end
    end
    checkOutput("pclk_rise_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input int pat);
    int lat;
    pattern_sel = 2'(pat);
    enable = 1'b1;
    fd_cnt = 0;
    lat = 0;
    while (vsync !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    checkOutput("enable_to_vsync_latency", 32'(lat <= 2 * DIV), 32'd1);
  endtask

  task automatic runFrame(input int pat, input int fno, input int exp_fd,
                          input int next_pat, input bit drop);
    logic [9:0] s;
    for (int i = 0; i < FRAME; i++) begin
      nextRise(s);
      if (i == 0) begin
        checkOutput($sformatf("frame%0d_done_count", fno), 32'(fd_cnt), 32'(exp_fd));
        checkOutput($sformatf("frame%0d_busy", fno), 32'(busy), 32'd1);
        fd_cnt = 0;
      end
      checkOutput($sformatf("frame%0d_pclk%0d", fno, i), 32'(s), 32'(refSample(pat, fno, i)));
      if (i == 10) pattern_sel = 2'($urandom);
      if (i == 70) pattern_sel = 2'(next_pat);
      if (drop && i == (VS + VBP + 2) * L + 3) enable = 1'b0;
    end
  endtask

  task automatic waitIdle(input string tag);
    int n;
    int toggles;
    logic last;
    n = 0;
    while (fd_cnt == 0 && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_frame_done"}, 32'(fd_cnt), 32'd1);
    checkOutput({tag, "_busy_low"}, 32'(busy), 32'd0);
    checkOutput({tag, "_vsync_low"}, 32'(vsync), 32'd0);
    fd_cnt = 0;
    toggles = 0;
    last = pclk;
    repeat (20) begin
      tick();
      if (pclk !== last) toggles++;
      last = pclk;
    end
    checkOutput({tag, "_pclk_static"}, 32'(toggles), 32'd0);
    checkOutput({tag, "_single_done_pulse"}, 32'(fd_cnt), 32'd0);
  endtask

  initial begin
    int   toggles, nonzero, n, p;
    int   pats[6];
    logic last;

    rst = 1'b1;
    enable = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) tick();
    checkOutput("reset_outputs", 32'({pclk, vsync, href, data, frame_done, busy}), 32'd0);
    rst = 1'b0;

    toggles = 0;
    nonzero = 0;
    last = pclk;
    repeat (100) begin
      tick();
      if (pclk !== last) toggles++;
      last = pclk;
      if ({vsync, href, data, frame_done, busy} !== 12'd0) nonzero++;
    end
    checkOutput("idle_pclk_toggles", 32'(toggles), 32'd0);
    checkOutput("idle_outputs_nonzero", 32'(nonzero), 32'd0);

    pats[0] = 0;
    pats[1] = 3;
    for (int i = 2; i < 6; i++) pats[i] = int'($urandom_range(0, 3));
    $display("[TB] continuous run, patterns %0d %0d %0d %0d %0d",
             pats[0], pats[1], pats[2], pats[3], pats[4]);
    applyStimulus(pats[0]);
    for (int f = 0; f < 5; f++) runFrame(pats[f], f, (f == 0) ? 0 : 1, pats[f + 1], f == 4);
    waitIdle("drop");

    applyStimulus(int'($urandom_range(0, 3)));
    n = 0;
    while (href !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checkOutput("midline_href_seen", 32'(href === 1'b1), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("midline_reset_outputs", 32'({pclk, vsync, href, data, frame_done, busy}), 32'd0);
    enable = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checkOutput("post_reset_busy", 32'(busy), 32'd0);

    p = int'($urandom_range(0, 3));
    $display("[TB] single frame after reset, pattern %0d", p);
    applyStimulus(p);
    runFrame(p, 0, 0, p, 1'b1);
    waitIdle("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
